// File: rtl/loader_pkg.sv
// Shared types and default parameters for the ioctl image loader.
`timescale 1ns/1ps
package loader_pkg;

   localparam int unsigned DEF_ADDR_W     = 14;
   localparam int unsigned DEF_IMG_BYTES  = 16000;
   localparam int unsigned DEF_FIFO_DEPTH = 4;
   localparam int unsigned IOCTL_ADDR_W   = 27;
   localparam int unsigned DATA_W         = 8;
   // Entry address field is wide enough for any RAM this loader targets (ADDR_W <= 24).
   localparam int unsigned ENTRY_ADDR_W   = 24;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [ENTRY_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]       data;
   } entry_t;

endpackage

// File: rtl/loader_fifo.sv
// Synchronous write buffer between the ioctl byte stream and the image RAM.
`timescale 1ns/1ps
module loader_fifo
   import loader_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  entry_t           push_data,
   input  logic             pop,
   output entry_t           head_c,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_full_nxt_c,
   output logic [CNT_W-1:0] count
);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_nxt;
   logic             do_push;
   logic             do_pop;

   // A push into a full buffer is taken only when the head leaves in the same cycle.
   always_comb begin
      do_push   = push && (!full || pop);
      do_pop    = pop && !empty;
      count_nxt = count;
      if (do_push && !do_pop) begin
         count_nxt = count + 1'b1;
      end else if (do_pop && !do_push) begin
         count_nxt = count - 1'b1;
      end
   end

   assign almost_full_nxt_c = (count_nxt >= CNT_W'(DEPTH - 1));
   assign head_c            = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         full        <= 1'b0;
         empty       <= 1'b1;
         almost_full <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count       <= count_nxt;
         full        <= (count_nxt == CNT_W'(DEPTH));
         empty       <= (count_nxt == '0);
         almost_full <= almost_full_nxt_c;
      end
   end

endmodule

// File: rtl/ioctl_image_loader.sv
// Streams an hps_io ioctl download into the soc image RAM through a small write buffer.
`timescale 1ns/1ps
module ioctl_image_loader
   import loader_pkg::*;
#(
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned IMG_BYTES  = DEF_IMG_BYTES,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                    clk_sys,
   input  logic                    reset_n,
   input  logic                    ioctl_download,
   input  logic                    ioctl_wr,
   input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
   input  logic [DATA_W-1:0]       ioctl_dout,
   output logic                    ioctl_wait,
   output logic                    ram_we,
   output logic [ADDR_W-1:0]       ram_addr,
   output logic [DATA_W-1:0]       ram_din,
   input  logic                    ram_busy,
   output logic                    progress,
   output logic                    done,
   output logic                    overflow,
   output logic [ADDR_W:0]         byte_count
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   state_t           state_q;
   state_t           state_d;
   logic             dl_q;
   logic             restart_q;
   logic             restart_d;
   logic             start_c;
   logic             dl_rise_c;
   logic             dl_fall_c;
   logic             push_c;
   logic             pop_c;
   logic             drop_c;
   logic             wr_load_c;
   logic             in_range_c;
   entry_t           push_entry;
   entry_t           head_c;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_af_unused;
   logic             fifo_af_nxt;
   logic [CNT_W-1:0] fifo_count_unused;

   assign dl_rise_c  = ioctl_download && !dl_q;
   assign dl_fall_c  = !ioctl_download && dl_q;
   assign in_range_c = (ioctl_addr < IOCTL_ADDR_W'(IMG_BYTES));
   assign wr_load_c  = ioctl_wr && (state_q == LOAD);
   assign pop_c      = !fifo_empty && !ram_busy;
   assign push_c     = wr_load_c && in_range_c && (!fifo_full || pop_c);
   assign drop_c     = wr_load_c && !push_c;

   assign push_entry.addr = ENTRY_ADDR_W'(ioctl_addr[ADDR_W-1:0]);
   assign push_entry.data = ioctl_dout;

   loader_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk               (clk_sys),
      .rst_n             (reset_n),
      .push              (push_c),
      .push_data         (push_entry),
      .pop               (pop_c),
      .head_c            (head_c),
      .full              (fifo_full),
      .empty             (fifo_empty),
      .almost_full       (fifo_af_unused),
      .almost_full_nxt_c (fifo_af_nxt),
      .count             (fifo_count_unused)
   );

   // Next-state logic; a rise seen during DRAIN is remembered and taken once the buffer is flushed.
   always_comb begin
      state_d   = state_q;
      restart_d = restart_q;
      start_c   = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (dl_rise_c) begin
               state_d = LOAD;
               start_c = 1'b1;
            end
         end
         LOAD: begin
            if (dl_fall_c) state_d = DRAIN;
         end
         DRAIN: begin
            if (dl_rise_c) restart_d = 1'b1;
            if (fifo_empty && !ram_we) begin
               restart_d = 1'b0;
               if ((restart_q || dl_rise_c) && ioctl_download) begin
                  state_d = LOAD;
                  start_c = 1'b1;
               end else begin
                  state_d = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         restart_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         restart_q <= restart_d;
      end
   end

   // dl_q resets high so a download already active at reset release is not seen as a new edge.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         dl_q       <= 1'b1;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_din    <= '0;
         ioctl_wait <= 1'b0;
         progress   <= 1'b0;
         done       <= 1'b0;
         overflow   <= 1'b0;
         byte_count <= '0;
      end else begin
         dl_q       <= ioctl_download;
         ram_we     <= pop_c;
         if (pop_c) begin
            ram_addr <= ADDR_W'(head_c.addr);
            ram_din  <= head_c.data;
         end
         ioctl_wait <= fifo_af_nxt || (state_d == DRAIN);
         progress   <= (state_d == LOAD) || (state_d == DRAIN);
         done       <= (state_d == DONE);
         if (start_c) begin
            overflow   <= 1'b0;
            byte_count <= '0;
         end else begin
            if (drop_c) overflow <= 1'b1;
            if (ram_we && (byte_count != '1)) byte_count <= byte_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ioctl_image_loader.sv
// Directed bench for ioctl_image_loader with a write-order scoreboard on the RAM port.
`timescale 1ns/1ps
module tb_ioctl_image_loader;
   import loader_pkg::*;

   localparam int unsigned ADDR_W = 14;

   logic              clk_sys = 1'b0;
   logic              reset_n = 1'b0;
   logic              ioctl_download = 1'b0;
   logic              ioctl_wr = 1'b0;
   logic [26:0]       ioctl_addr = '0;
   logic [7:0]        ioctl_dout = '0;
   logic              ioctl_wait;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_din;
   logic              ram_busy = 1'b0;
   logic              progress;
   logic              done;
   logic              overflow;
   logic [ADDR_W:0]   byte_count;

   int checks = 0;
   int errors = 0;
   int wcount = 0;
   logic [ADDR_W+7:0] exp_q[$];

   ioctl_image_loader #(
      .ADDR_W     (ADDR_W),
      .IMG_BYTES  (16000),
      .FIFO_DEPTH (4)
   ) dut (
      .clk_sys        (clk_sys),
      .reset_n        (reset_n),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .ram_we         (ram_we),
      .ram_addr       (ram_addr),
      .ram_din        (ram_din),
      .ram_busy       (ram_busy),
      .progress       (progress),
      .done           (done),
      .overflow       (overflow),
      .byte_count     (byte_count)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // One-cycle byte strobe; ok marks bytes that must reach the RAM.
   task automatic send(input int addr, input logic [7:0] data, input bit ok, input bit honor_wait);
      int n = 0;
      if (honor_wait) begin
         while (ioctl_wait && n < 100) begin
            tick();
            n++;
         end
         if (ioctl_wait) check("wait_timeout", 32'(ioctl_wait), 0);
      end
      ioctl_wr   = 1'b1;
      ioctl_addr = 27'(addr);
      ioctl_dout = data;
      if (ok) exp_q.push_back({ADDR_W'(addr), data});
      tick();
      ioctl_wr = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 200) begin
         tick();
         n++;
      end
      check(tag, 32'(done), 1);
   endtask

   // RAM-side scoreboard: every write must match the oldest outstanding accepted byte.
   always @(negedge clk_sys) begin
      logic [ADDR_W+7:0] e;
      if (reset_n && ram_we) begin
         if (exp_q.size() == 0) begin
            check("ram_we_unexpected", 32'(ram_we), 0);
         end else begin
            e = exp_q.pop_front();
            check("ram_addr", 32'(ram_addr), 32'(e[ADDR_W+7:8]));
            check("ram_din", 32'(ram_din), 32'(e[7:0]));
         end
         wcount++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      int wc0;
      int n;
      ioctl_download = 1'b1;
      repeat (3) tick();
      check("rst_ram_we", 32'(ram_we), 0);
      check("rst_wait", 32'(ioctl_wait), 0);
      check("rst_ram_addr", 32'(ram_addr), 0);
      check("rst_ram_din", 32'(ram_din), 0);
      check("rst_progress", 32'(progress), 0);
      check("rst_done", 32'(done), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_count", 32'(byte_count), 0);
      reset_n = 1'b1;
      repeat (4) tick();
      check("no_start_at_release", 32'(progress), 0);
      ioctl_download = 1'b0;
      tick();

      // Full image, back to back
      ioctl_download = 1'b1;
      tick();
      check("t1_progress", 32'(progress), 1);
      for (int a = 0; a < 16000; a++) send(a, 8'(a ^ (a >> 8)), 1'b1, 1'b1);
      ioctl_download = 1'b0;
      wait_done("t1_done");
      check("t1_count", 32'(byte_count), 16000);
      check("t1_overflow", 32'(overflow), 0);
      check("t1_progress_low", 32'(progress), 0);
      check("t1_writes", 32'(wcount), 16000);
      check("t1_queue_empty", 32'(exp_q.size()), 0);

      // Out-of-range addresses
      ioctl_download = 1'b1;
      tick();
      check("t2_done_clr", 32'(done), 0);
      check("t2_count_clr", 32'(byte_count), 0);
      send(16000, 8'h11, 1'b0, 1'b1);
      check("t2_ovf_16000", 32'(overflow), 1);
      send(20000, 8'h12, 1'b0, 1'b1);
      send(100, 8'h21, 1'b1, 1'b1);
      send(15999, 8'h22, 1'b1, 1'b1);
      send(0, 8'h23, 1'b1, 1'b1);
      ioctl_download = 1'b0;
      wait_done("t2_done");
      check("t2_count", 32'(byte_count), 3);
      check("t2_overflow", 32'(overflow), 1);
      check("t2_writes", 32'(wcount), 16003);

      // Write on the falling edge of download, latency and hold
      ioctl_download = 1'b1;
      tick();
      check("t3_ovf_clr", 32'(overflow), 0);
      ioctl_wr = 1'b1;
      ioctl_addr = 27'd5;
      ioctl_dout = 8'hA5;
      ioctl_download = 1'b0;
      exp_q.push_back({ADDR_W'(5), 8'hA5});
      tick();
      ioctl_wr = 1'b0;
      check("t3_lat1_we", 32'(ram_we), 0);
      check("t3_drain_wait", 32'(ioctl_wait), 1);
      tick();
      check("t3_lat2_we", 32'(ram_we), 1);
      check("t3_lat2_addr", 32'(ram_addr), 5);
      wait_done("t3_done");
      check("t3_count", 32'(byte_count), 1);
      repeat (3) tick();
      check("t3_hold_we", 32'(ram_we), 0);
      check("t3_hold_addr", 32'(ram_addr), 5);
      check("t3_hold_din", 32'(ram_din), 32'h A5);

      // RAM back-pressure, full FIFO, push+pop when full, drop when full
      ioctl_download = 1'b1;
      tick();
      ram_busy = 1'b1;
      send(10, 8'h31, 1'b1, 1'b1);
      send(11, 8'h32, 1'b1, 1'b1);
      check("t4_wait_at2", 32'(ioctl_wait), 0);
      send(12, 8'h33, 1'b1, 1'b1);
      check("t4_wait_at3", 32'(ioctl_wait), 1);
      wc0 = wcount;
      repeat (20) tick();
      check("t4_busy_no_we", 32'(wcount - wc0), 0);
      send(13, 8'h34, 1'b1, 1'b0);
      ram_busy = 1'b0;
      send(14, 8'h35, 1'b1, 1'b0);
      check("t4_pushpop_full_ovf", 32'(overflow), 0);
      ram_busy = 1'b1;
      send(15, 8'h36, 1'b0, 1'b0);
      check("t4_full_drop_ovf", 32'(overflow), 1);
      ioctl_download = 1'b0;
      tick();
      check("t4_drain_wait", 32'(ioctl_wait), 1);
      check("t4_drain_progress", 32'(progress), 1);
      ram_busy = 1'b0;
      wait_done("t4_done");
      check("t4_count", 32'(byte_count), 5);
      check("t4_queue_empty", 32'(exp_q.size()), 0);

      // Reset while bytes are buffered and a write is on the RAM port
      ioctl_download = 1'b1;
      tick();
      ram_busy = 1'b1;
      send(30, 8'h41, 1'b1, 1'b1);
      send(31, 8'h42, 1'b1, 1'b1);
      send(32, 8'h43, 1'b1, 1'b1);
      ram_busy = 1'b0;
      tick();
      check("t5_we_before_rst", 32'(ram_we), 1);
      reset_n = 1'b0;
      #1;
      check("t5_rst_we", 32'(ram_we), 0);
      check("t5_rst_progress", 32'(progress), 0);
      check("t5_rst_wait", 32'(ioctl_wait), 0);
      exp_q.delete();
      wc0 = wcount;
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (10) tick();
      check("t5_no_writes", 32'(wcount - wc0), 0);
      check("t5_no_start", 32'(progress), 0);
      ioctl_download = 1'b0;
      tick();

      // Second download raised while the first is still draining
      ioctl_download = 1'b1;
      tick();
      ram_busy = 1'b1;
      send(40, 8'h51, 1'b1, 1'b1);
      send(41, 8'h52, 1'b1, 1'b1);
      send(42, 8'h53, 1'b1, 1'b1);
      ioctl_download = 1'b0;
      tick();
      ioctl_download = 1'b1;
      tick();
      check("t6_in_drain", 32'(ioctl_wait), 1);
      ram_busy = 1'b0;
      n = 0;
      while (byte_count != 15'd3 && n < 50) begin
         tick();
         n++;
      end
      check("t6_first_count", 32'(byte_count), 3);
      tick();
      check("t6_count_clr", 32'(byte_count), 0);
      check("t6_progress", 32'(progress), 1);
      check("t6_no_done", 32'(done), 0);
      check("t6_wait_low", 32'(ioctl_wait), 0);
      send(50, 8'h61, 1'b1, 1'b1);
      send(51, 8'h62, 1'b1, 1'b1);
      ioctl_download = 1'b0;
      wait_done("t6_done");
      check("t6_count", 32'(byte_count), 2);
      check("t6_queue_empty", 32'(exp_q.size()), 0);
      check("t6_overflow", 32'(overflow), 0);

      repeat (5) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ioctl_image_loader.md
IOCTL_IMAGE_LOADER -- requirements
Module: ioctl_image_loader

Interface
REQ-001 Parameter ADDR_W, default 14: width of the image RAM byte address.
REQ-002 Parameter IMG_BYTES, default 16000: image size in bytes; addresses at or above this are out of range.
REQ-003 Parameter FIFO_DEPTH, default 4: entries in the internal write buffer; power of two, at least 2.
REQ-004 Port clk_sys, input, 1: single core clock, the same clock as hps_io.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port ioctl_download, input, 1: download-active level from hps_io.
REQ-007 Port ioctl_wr, input, 1: one-cycle byte strobe.
REQ-008 Port ioctl_addr, input, 27: byte address within the file.
REQ-009 Port ioctl_dout, input, 8: byte data.
REQ-010 Port ioctl_wait, output, 1: back-pressure to hps_io.
REQ-011 Port ram_we, output, 1: write strobe to the soc image RAM.
REQ-012 Port ram_addr, output, ADDR_W: RAM byte address.
REQ-013 Port ram_din, output, 8: RAM write data.
REQ-014 Port ram_busy, input, 1: RAM cannot accept a write this cycle.
REQ-015 Port progress, output, 1: load in progress; drives LED_USER.
REQ-016 Port done, output, 1: last load completed.
REQ-017 Port overflow, output, 1: sticky flag; an out-of-range byte or a FIFO-full byte was dropped.
REQ-018 Port byte_count, output, ADDR_W+1: bytes written to RAM in the current load; saturates at all-ones.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, DRAIN and DONE.
REQ-020 IDLE and DONE SHALL go to LOAD on a rising edge of ioctl_download, detected against a registered copy of ioctl_download. That transition SHALL clear byte_count, overflow and done.
REQ-021 LOAD SHALL go to DRAIN on a falling edge of ioctl_download.
REQ-022 DRAIN SHALL go to DONE when the FIFO is empty and no RAM write is pending. DONE SHALL set done=1.
REQ-023 If ioctl_download rises during DRAIN, the FSM SHALL finish draining and then go DRAIN->LOAD directly, with the clears from REQ-020 applied at that transition.
REQ-024 progress SHALL equal 1 exactly in LOAD and DRAIN.
REQ-025 A byte SHALL be accepted when ioctl_wr=1, the state is LOAD, ioctl_addr < IMG_BYTES, and the FIFO is not full. An accepted byte pushes {ioctl_addr[ADDR_W-1:0], ioctl_dout}.
REQ-026 ioctl_wr coinciding with the falling edge of ioctl_download SHALL still be accepted.
REQ-027 ioctl_wr with ioctl_addr >= IMG_BYTES SHALL be discarded and SHALL set overflow.
REQ-028 ioctl_wr while the FIFO is full SHALL be discarded and SHALL set overflow.
REQ-029 ioctl_wr outside LOAD SHALL be ignored.
REQ-030 ioctl_wait SHALL be a registered output, 1 when FIFO occupancy >= FIFO_DEPTH-1 or the state is DRAIN; 0 otherwise.
REQ-031 Pop rule: when the FIFO is non-empty and ram_busy=0, the head entry SHALL be popped. On the next cycle ram_we=1 for exactly one cycle, with ram_addr/ram_din holding the popped entry.
REQ-032 Minimum latency from ioctl_wr into an empty FIFO to ram_we SHALL be 2 cycles.
REQ-033 Push and pop in the same cycle SHALL leave occupancy unchanged. Push into a full FIFO in the same cycle as a pop SHALL be accepted.
REQ-034 Write order into RAM SHALL equal accept order.
REQ-035 byte_count SHALL increment on each ram_we cycle.
REQ-036 ram_addr and ram_din SHALL hold their last values while ram_we=0.

Reset
REQ-037 While reset_n=0: state=IDLE, FIFO empty.
REQ-038 While reset_n=0: ioctl_wait=0, ram_we=0, ram_addr=0, ram_din=0, progress=0, done=0, overflow=0, byte_count=0.
REQ-039 Reset asserted mid-load SHALL abort immediately and issue no further ram_we.
REQ-040 After reset release, a load SHALL start only on a fresh rising edge of ioctl_download. A download already high at release SHALL NOT start a load.

Structure
REQ-041 Package loader_pkg SHALL hold the state enum type, the FIFO entry struct {addr, data}, and the default parameter constants.
REQ-042 The FIFO SHALL be a separate sub-module, loader_fifo: synchronous, with registered occupancy and full/empty/almost_full flags.

Verification
REQ-043 Reset release, download high for 16000 back-to-back bytes at addresses 0..15999 with ram_busy=0 -> 16000 ram_we pulses in address order; byte_count=16000; done=1; overflow=0; progress low after drain.
REQ-044 ram_busy held high 20 cycles mid-load -> ioctl_wait=1 once occupancy reaches 3; zero bytes lost; data order preserved.
REQ-045 Write to ioctl_addr=16000 and to 20000 -> no ram_we for either; overflow=1; byte_count excludes them.
REQ-046 ioctl_wr on the same cycle ioctl_download falls (addr 5, data 0xA5) -> ram_we with ram_addr=5, ram_din=0xA5; then done=1.
REQ-047 reset_n pulled low with 3 entries buffered -> ram_we=0 immediately; no writes after release until a new download rising edge.
REQ-048 Second download started during DRAIN -> first load completes; byte_count clears at DRAIN->LOAD; second image written correctly.
